// File: rtl/sprite_row_fetcher_if.sv
// -----------------------------------------------------------------------------
// sprite_row_fetcher_if
// Bundles the request handshake, sprite memory read port and row output
// handshake of sprite_row_fetcher.
//   slave  : the fetcher itself (takes requests, drives memory reads and rows)
//   master : the environment (issues requests, models memory, consumes rows)
// Signals:
//   req_valid/req_ready, req_sprite[5:0], req_row[3:0], req_hflip, req_vflip
//   cancel                     synchronous abort of the current row
//   mem_ren, mem_raddr[13:0]   bit address {sprite, row, col}
//   mem_rdata                  registered read data, one cycle after mem_ren
//   row_valid/row_ready, row_data[15:0] (bit 15 = leftmost pixel), busy
// -----------------------------------------------------------------------------
interface sprite_row_fetcher_if;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_sprite;
  logic [3:0]  req_row;
  logic        req_hflip;
  logic        req_vflip;
  logic        cancel;
  logic        mem_ren;
  logic [13:0] mem_raddr;
  logic        mem_rdata;
  logic        row_valid;
  logic        row_ready;
  logic [15:0] row_data;
  logic        busy;

  modport slave (
    input  req_valid, req_sprite, req_row, req_hflip, req_vflip, cancel,
    input  mem_rdata, row_ready,
    output req_ready, mem_ren, mem_raddr, row_valid, row_data, busy
  );

  modport master (
    output req_valid, req_sprite, req_row, req_hflip, req_vflip, cancel,
    output mem_rdata, row_ready,
    input  req_ready, mem_ren, mem_raddr, row_valid, row_data, busy
  );
endinterface

// File: rtl/sprite_row_fetcher.sv
// -----------------------------------------------------------------------------
// sprite_row_fetcher
// Fetches one 16-pixel row of a 64 x 16x16 x 1bpp sprite from a bit-wide
// sprite memory, applying optional horizontal/vertical mirroring, and holds
// the assembled row until the consumer takes it.
// Ports:
//   clk     rising-edge clock
//   resetn  asynchronous active-low reset
//   bus     sprite_row_fetcher_if.slave (request, memory and row handshakes)
// Timing: a request accepted at edge E0 issues 16 reads in the 16 cycles
// after E0; the row is presented (row_valid) after edge E0+17.
// -----------------------------------------------------------------------------
module sprite_row_fetcher (
  input  logic                 clk,
  input  logic                 resetn,
  sprite_row_fetcher_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [1:0]  state_r,     state_nxt_s;
  logic [4:0]  cnt_r,       cnt_nxt_s;
  logic [5:0]  sprite_r,    sprite_nxt_s;
  logic [3:0]  row_r,       row_nxt_s;
  logic        hflip_r,     hflip_nxt_s;
  logic [15:0] row_data_r,  data_nxt_s;
  logic        mem_ren_r,   mem_ren_nxt_s;
  logic [13:0] mem_raddr_r, mem_raddr_nxt_s;
  logic        row_valid_r, row_valid_nxt_s;
  logic        busy_r,      busy_nxt_s;
  logic [3:0]  col_s;

  // Vertical mirror selects the row counted from the bottom of the sprite.
  function automatic logic [3:0] eff_row_f(input logic [3:0] row, input logic vflip);
    return vflip ? (4'd15 - row) : row;
  endfunction

  // Column c lands in bit 15-c normally (bit 15 = leftmost), or bit c when mirrored.
  function automatic logic [3:0] bit_idx_f(input logic [3:0] col, input logic hflip);
    return hflip ? col : (4'd15 - col);
  endfunction

  // Next-state, pixel capture and next values of the registered outputs.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    sprite_nxt_s = sprite_r;
    row_nxt_s    = row_r;
    hflip_nxt_s  = hflip_r;
    data_nxt_s   = row_data_r;
    // Data arriving now belongs to the address issued last cycle (cnt-1);
    // at cnt=16 the low nibble wraps to 0 and col_s becomes 15.
    col_s        = cnt_r[3:0] - 4'd1;
    case (state_r)
      ST_IDLE: begin
        if (bus.req_valid) begin
          state_nxt_s  = ST_FETCH;
          cnt_nxt_s    = 5'd0;
          sprite_nxt_s = bus.req_sprite;
          row_nxt_s    = eff_row_f(bus.req_row, bus.req_vflip);
          hflip_nxt_s  = bus.req_hflip;
          data_nxt_s   = 16'd0;
        end else begin
          cnt_nxt_s    = 5'd0;
        end
      end
      ST_FETCH: begin
        if (bus.cancel) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 5'd0;
        end else begin
          if (cnt_r != 5'd0) begin
            data_nxt_s[bit_idx_f(col_s, hflip_r)] = bus.mem_rdata;
          end else begin
            data_nxt_s = row_data_r;
          end
          if (cnt_r == 5'd16) begin
            state_nxt_s = ST_HOLD;
            cnt_nxt_s   = 5'd0;
          end else begin
            cnt_nxt_s   = cnt_r + 5'd1;
          end
        end
      end
      ST_HOLD: begin
        // cancel and row_ready both release the row; neither allows a new
        // request in this same cycle because req_ready is low in HOLD.
        if (bus.cancel || (row_valid_r && bus.row_ready)) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 5'd0;
      end
    endcase

    mem_ren_nxt_s = (state_nxt_s == ST_FETCH) && !cnt_nxt_s[4];
    if (mem_ren_nxt_s) begin
      mem_raddr_nxt_s = {sprite_nxt_s, row_nxt_s, cnt_nxt_s[3:0]};
    end else begin
      mem_raddr_nxt_s = 14'd0;
    end
    row_valid_nxt_s = (state_nxt_s == ST_HOLD);
    busy_nxt_s      = (state_nxt_s != ST_IDLE);
  end

  // State, request context, row assembly and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 5'd0;
      sprite_r    <= 6'd0;
      row_r       <= 4'd0;
      hflip_r     <= 1'b0;
      row_data_r  <= 16'd0;
      mem_ren_r   <= 1'b0;
      mem_raddr_r <= 14'd0;
      row_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      sprite_r    <= sprite_nxt_s;
      row_r       <= row_nxt_s;
      hflip_r     <= hflip_nxt_s;
      row_data_r  <= data_nxt_s;
      mem_ren_r   <= mem_ren_nxt_s;
      mem_raddr_r <= mem_raddr_nxt_s;
      row_valid_r <= row_valid_nxt_s;
      busy_r      <= busy_nxt_s;
    end
  end

  assign bus.req_ready = (state_r == ST_IDLE);
  assign bus.mem_ren   = mem_ren_r;
  assign bus.mem_raddr = mem_raddr_r;
  assign bus.row_valid = row_valid_r;
  assign bus.row_data  = row_data_r;
  assign bus.busy      = busy_r;

endmodule
